fifo_wr_ptr: RTL and testbench



---
 rtl/fifo_wr_ptr_if.sv | 25 ++
 rtl/fifo_wr_ptr.sv | 66 ++++++
 tb/tb_fifo_wr_ptr.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_ptr_if.sv
// Write-side handshake and status bundle for the async FIFO write pointer controller.
// master = write client / read-pointer synchroniser side, slave = fifo_wr_ptr.
interface fifo_wr_ptr_if #(
  parameter int ADDR_W = 3
);
  logic              push_i;
  logic [ADDR_W:0]   rd_addr_synch_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_idx_o;
  logic [ADDR_W:0]   wr_addr_o;
  logic [ADDR_W:0]   level_o;
  logic              full_o;
  logic              almost_full_o;
  logic              overflow_o;

  modport master (
    output push_i, rd_addr_synch_i,
    input  wr_en_o, wr_idx_o, wr_addr_o, level_o, full_o, almost_full_o, overflow_o
  );

  modport slave (
    input  push_i, rd_addr_synch_i,
    output wr_en_o, wr_idx_o, wr_addr_o, level_o, full_o, almost_full_o, overflow_o
  );
endinterface

// File: rtl/fifo_wr_ptr.sv
// Async FIFO write-side pointer controller: binary write pointer with wrap bit,
// full gating, fill level, almost-full and sticky overflow. Synchronous active-low rst.
module fifo_wr_ptr #(
  parameter int ADDR_W = 3,
  parameter int AF_LVL = 6
) (
  input  logic         clk,
  input  logic         rst,
  fifo_wr_ptr_if.slave bus
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_W    = AF_LVL[ADDR_W:0];

  logic [ADDR_W:0] wr_addr_q;
  logic [ADDR_W:0] level_q;
  logic            full_q;
  logic            almost_full_q;
  logic            overflow_q;

  logic            accept;
  logic [ADDR_W:0] wr_addr_next;
  logic [ADDR_W:0] raw_level;
  logic [ADDR_W:0] level_next;

  // Strobe is suppressed during reset so a held push cannot write memory.
  assign accept = rst && bus.push_i && !full_q;

  always_comb begin
    wr_addr_next = wr_addr_q + {{ADDR_W{1'b0}}, accept};
    raw_level    = wr_addr_next - bus.rd_addr_synch_i;
    level_next   = raw_level;
    // A corrupt synchronised read pointer reads as full, blocking writes until it recovers.
    if (raw_level > DEPTH_W) begin
      level_next = DEPTH_W;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_addr_q     <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_addr_q     <= wr_addr_next;
      level_q       <= level_next;
      full_q        <= (level_next == DEPTH_W);
      almost_full_q <= (level_next >= AF_W);
      if (bus.push_i && full_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.wr_en_o       = accept;
  assign bus.wr_idx_o      = wr_addr_q[ADDR_W-1:0];
  assign bus.wr_addr_o     = wr_addr_q;
  assign bus.level_o       = level_q;
  assign bus.full_o        = full_q;
  assign bus.almost_full_o = almost_full_q;
  assign bus.overflow_o    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ptr.sv
// Self-checking bench for fifo_wr_ptr (ADDR_W=3, AF_LVL=6): a reference model pushes
// expected post-edge state into a scoreboard queue that is popped after each edge.
module tb_fifo_wr_ptr;
  localparam int AW  = 3;
  localparam int D   = 8;
  localparam int AF  = 6;
  localparam int PM  = 15;

  typedef struct {
    int wa;
    int lvl;
    int full;
    int af;
    int ovf;
  } exp_t;

  logic clk;
  logic rst;
  fifo_wr_ptr_if #(.ADDR_W(AW)) bus ();

  fifo_wr_ptr #(.ADDR_W(AW), .AF_LVL(AF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  // model state (post-edge values)
  int m_wa, m_lvl, m_full, m_af, m_ovf;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational strobe, then registered state.
  task automatic step(input logic rst_v, input logic push, input int rd);
    int   exp_wen;
    int   raw;
    exp_t e;
    exp_t o;
    @(negedge clk);
    rst = rst_v;
    bus.push_i = push;
    bus.rd_addr_synch_i = rd[AW:0];
    exp_wen = (rst_v && push && !m_full) ? 1 : 0;
    if (!rst_v) begin
      m_wa = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      if (push && m_full) m_ovf = 1;
      m_wa  = (m_wa + exp_wen) & PM;
      raw   = (m_wa - rd) & PM;
      m_lvl = (raw > D) ? D : raw;
      m_full = (m_lvl == D) ? 1 : 0;
      m_af   = (m_lvl >= AF) ? 1 : 0;
    end
    e.wa = m_wa; e.lvl = m_lvl; e.full = m_full; e.af = m_af; e.ovf = m_ovf;
    sb.push_back(e);
    #1;
    chk("wr_en", int'(bus.wr_en_o), exp_wen);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      o = sb.pop_front();
      chk("wr_addr", int'(bus.wr_addr_o), o.wa);
      chk("wr_idx", int'(bus.wr_idx_o), o.wa & (D - 1));
      chk("level", int'(bus.level_o), o.lvl);
      chk("full", int'(bus.full_o), o.full);
      chk("almost_full", int'(bus.almost_full_o), o.af);
      chk("overflow", int'(bus.overflow_o), o.ovf);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_wrap;
    int prev_wa;
    rst = 1'b0;
    bus.push_i = 1'b0;
    bus.rd_addr_synch_i = '0;
    m_wa = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;

    // 1: reset held with push, then first push
    do_reset();
    chk("rst_wr_addr", int'(bus.wr_addr_o), 0);
    chk("rst_level", int'(bus.level_o), 0);
    step(1'b1, 1'b1, 0);
    chk("t1_addr", int'(bus.wr_addr_o), 1);
    chk("t1_level", int'(bus.level_o), 1);

    // 2: fill to full, then overflow
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 0);
      chk("t2_af", int'(bus.almost_full_o), (i >= 5) ? 1 : 0);
      chk("t2_full", int'(bus.full_o), (i == 7) ? 1 : 0);
    end
    chk("t2_addr8", int'(bus.wr_addr_o), 8);
    chk("t2_level8", int'(bus.level_o), 8);
    step(1'b1, 1'b1, 0);
    chk("t2_ovf", int'(bus.overflow_o), 1);
    chk("t2_addr_hold", int'(bus.wr_addr_o), 8);

    // 3: read advance frees one slot
    step(1'b1, 1'b0, 1);
    chk("t3_level7", int'(bus.level_o), 7);
    chk("t3_full0", int'(bus.full_o), 0);
    chk("t3_idx0", int'(bus.wr_idx_o), 0);
    step(1'b1, 1'b1, 1);
    chk("t3_addr9", int'(bus.wr_addr_o), 9);

    // 4: wrap-around with read trailing by 2
    do_reset();
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 0);
    saw_wrap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prev_wa = m_wa;
      step(1'b1, 1'b1, (m_wa + 1 - 2) & PM);
      if (prev_wa == 15 && int'(bus.wr_addr_o) == 0) saw_wrap = 1'b1;
      chk("t4_level2", int'(bus.level_o), 2);
    end
    chk("t4_wrap", int'(saw_wrap), 1);
    chk("t4_ovf0", int'(bus.overflow_o), 0);

    // 5: push at level 7 with simultaneous read advance
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 0);
    chk("t5_level7", int'(bus.level_o), 7);
    step(1'b1, 1'b1, 1);
    chk("t5_level_hold", int'(bus.level_o), 7);
    chk("t5_full0", int'(bus.full_o), 0);

    // 6: corrupt read pointer saturates, then mid-stream reset
    step(1'b1, 1'b0, (m_wa + 3) & PM);
    chk("t6_level_sat", int'(bus.level_o), 8);
    chk("t6_full", int'(bus.full_o), 1);
    step(1'b1, 1'b1, (m_wa + 3) & PM);
    chk("t6_ovf", int'(bus.overflow_o), 1);
    step(1'b0, 1'b1, 11);
    chk("t6_rst_addr", int'(bus.wr_addr_o), 0);
    chk("t6_rst_ovf", int'(bus.overflow_o), 0);
    chk("t6_rst_full", int'(bus.full_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
